// File: rtl/rapid_pkg.sv
// Shared types for the RAPID RV32I pipeline: decoded control bundle, issue-stage
// state encoding and the held-instruction slot layout.
package rapid_pkg;

  localparam int REG_COUNT  = 32;
  localparam int RAPID_XLEN = 32;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       use_imm;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
  } control_s;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    VALID = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } issue_state_t;

  typedef struct packed {
    logic [RAPID_XLEN-1:0] pc;
    logic [RAPID_XLEN-1:0] imm;
    control_s              control;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic                  rs1_used;
    logic                  rs2_used;
    logic                  rd_we;
  } issue_slot_s;

  function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [4:0] idx);
    reg_onehot = REG_COUNT'(1) << idx;
  endfunction

endpackage

// File: rtl/issue_controller_scoreboard.sv
// Pending-destination scoreboard: one busy bit per architectural register, with
// same-cycle writeback bypass on the hazard lookups.
module reg_scoreboard
  import rapid_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 clear_en,
  input  logic [4:0]           clear_idx,
  input  logic                 set_en,
  input  logic [4:0]           set_idx,
  input  logic [4:0]           rs1_idx,
  input  logic [4:0]           rs2_idx,
  input  logic [4:0]           rd_idx,
  output logic [REG_COUNT-1:0] busy_mask,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 rd_busy
);

  logic [REG_COUNT-1:0] clear_mask;
  logic [REG_COUNT-1:0] set_mask;
  logic [REG_COUNT-1:0] eff_busy;

  always_comb begin
    clear_mask = clear_en ? reg_onehot(clear_idx) : '0;
    set_mask   = (set_en && (set_idx != 5'd0)) ? reg_onehot(set_idx) : '0;
    eff_busy   = busy_mask & ~clear_mask;
  end

  assign rs1_busy = eff_busy[rs1_idx];
  assign rs2_busy = eff_busy[rs2_idx];
  assign rd_busy  = eff_busy[rd_idx];

  // Set is OR-ed after the clear so a same-register issue wins over writeback; x0 is never tracked.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      busy_mask <= '0;
    end else begin
      busy_mask <= (eff_busy | set_mask) & ~REG_COUNT'(1);
    end
  end

endmodule

// File: rtl/issue_controller.sv
// Decode-to-execute issue stage: holds one instruction, blocks on RAW/WAW hazards
// and in-flight credits, and sequences stall and flush.
module issue_controller
  import rapid_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_flush,
  input  logic                 i_de_valid,
  output logic                 o_de_ready,
  input  logic [XLEN-1:0]      i_de_pc,
  input  logic [XLEN-1:0]      i_de_imm,
  input  control_s             i_de_control,
  input  logic [4:0]           i_de_rs1,
  input  logic [4:0]           i_de_rs2,
  input  logic [4:0]           i_de_rd,
  input  logic                 i_de_rs1_used,
  input  logic                 i_de_rs2_used,
  input  logic                 i_de_rd_we,
  output logic                 o_ex_valid,
  input  logic                 i_ex_ready,
  output logic [XLEN-1:0]      o_ex_pc,
  output logic [XLEN-1:0]      o_ex_imm,
  output control_s             o_ex_control,
  output logic [4:0]           o_ex_rs1,
  output logic [4:0]           o_ex_rs2,
  output logic [4:0]           o_ex_rd,
  output logic                 o_ex_rd_we,
  input  logic                 i_wb_we,
  input  logic [4:0]           i_wb_rd,
  input  logic                 i_retire,
  output logic [REG_COUNT-1:0] o_busy_mask,
  output logic [CW-1:0]        o_inflight,
  output logic [31:0]          o_stall_cycles,
  output issue_state_t         o_state
);

  issue_state_t state;
  issue_state_t state_next;
  issue_slot_s  slot;
  issue_slot_s  incoming;
  logic [CW-1:0] inflight;
  logic [CW-1:0] inflight_after_retire;
  logic held, hazard, blocked, credit_ok, retire_eff, issue, accept;
  logic rs1_busy, rs2_busy, rd_busy;

  reg_scoreboard u_scoreboard (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .clear_en  (i_wb_we),
    .clear_idx (i_wb_rd),
    .set_en    (issue & slot.rd_we),
    .set_idx   (slot.rd),
    .rs1_idx   (slot.rs1),
    .rs2_idx   (slot.rs2),
    .rd_idx    (slot.rd),
    .busy_mask (o_busy_mask),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .rd_busy   (rd_busy)
  );

  // A retire at zero in-flight is spurious and must not free a credit.
  assign held                  = (state == VALID) || (state == STALL);
  assign retire_eff            = i_retire && (inflight != '0);
  assign inflight_after_retire = inflight - CW'(retire_eff);
  assign credit_ok             = inflight_after_retire < CW'(MAX_INFLIGHT);
  assign hazard     = (slot.rs1_used & rs1_busy) | (slot.rs2_used & rs2_busy) | (slot.rd_we & rd_busy);
  assign blocked    = hazard | ~credit_ok;
  assign o_ex_valid = held & ~blocked & ~i_flush;
  assign issue      = o_ex_valid & i_ex_ready;
  assign o_de_ready = ~i_flush & ((state == EMPTY) | issue);
  assign accept     = i_de_valid & o_de_ready;

  always_comb begin
    incoming          = '0;
    incoming.pc       = RAPID_XLEN'(i_de_pc);
    incoming.imm      = RAPID_XLEN'(i_de_imm);
    incoming.control  = i_de_control;
    incoming.rs1      = i_de_rs1;
    incoming.rs2      = i_de_rs2;
    incoming.rd       = i_de_rd;
    incoming.rs1_used = i_de_rs1_used;
    incoming.rs2_used = i_de_rs2_used;
    incoming.rd_we    = i_de_rd_we;
  end

  // Flush overrides every state; VALID and STALL share exits and differ only in why they wait.
  always_comb begin
    state_next = state;
    if (i_flush) begin
      state_next = FLUSH;
    end else begin
      case (state)
        EMPTY: if (accept) state_next = VALID;
        VALID, STALL: begin
          if (issue)        state_next = accept ? VALID : EMPTY;
          else if (blocked) state_next = STALL;
          else              state_next = VALID;
        end
        FLUSH:   state_next = EMPTY;
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= EMPTY;
      slot           <= '0;
      inflight       <= '0;
      o_stall_cycles <= '0;
    end else begin
      state <= state_next;
      if (i_flush)     slot <= '0;
      else if (accept) slot <= incoming;
      else if (issue)  slot <= '0;
      case ({issue, retire_eff})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      if ((state == STALL) && (o_stall_cycles != '1))
        o_stall_cycles <= o_stall_cycles + 32'd1;
    end
  end

  assign o_ex_pc      = XLEN'(slot.pc);
  assign o_ex_imm     = XLEN'(slot.imm);
  assign o_ex_control = slot.control;
  assign o_ex_rs1     = slot.rs1;
  assign o_ex_rs2     = slot.rs2;
  assign o_ex_rd      = slot.rd;
  assign o_ex_rd_we   = slot.rd_we;
  assign o_inflight   = inflight;
  assign o_state      = state;

endmodule

// File: doc/issue_controller.md
Name: issue_controller

Overview:
Sits between instruction_decoder and the execute stage of the RAPID RV32I pipeline. It holds one decoded instruction and tracks pending destination registers in a 32-entry scoreboard. It issues the held instruction to execute only when there is no RAW/WAW hazard, an in-flight credit is available and execute is ready. It owns the decode→execute handshake, stall and flush sequencing, and a stall performance counter.

Parameters:
XLEN, 32, datapath width for pc/imm.
MAX_INFLIGHT, 4, maximum issued-but-not-retired instructions; range 1..15.
CW, $clog2(MAX_INFLIGHT+1), width of the in-flight counter.

Ports:
i_clk  in  1  clock, rising edge.
i_reset  in  1  asynchronous, active-high reset.
i_flush  in  1  discard the held instruction (branch redirect).
i_de_valid  in  1  decoder presents an instruction.
o_de_ready  out  1  controller accepts this cycle.
i_de_pc, i_de_imm  in  XLEN each  decoded pc and immediate.
i_de_control  in  control_s  decoded control bundle.
i_de_rs1, i_de_rs2, i_de_rd  in  5 each  register indices.
i_de_rs1_used, i_de_rs2_used, i_de_rd_we  in  1 each  operand-read and destination-write enables.
o_ex_valid  out  1  held instruction offered to execute.
i_ex_ready  in  1  execute accepts.
o_ex_pc, o_ex_imm, o_ex_control, o_ex_rs1, o_ex_rs2, o_ex_rd, o_ex_rd_we  out  as inputs  held instruction fields, registered.
i_wb_we  in  1  writeback commits a register.
i_wb_rd  in  5  writeback destination.
i_retire  in  1  one issued instruction completed (any type).
o_busy_mask  out  32  scoreboard; bit 0 always 0.
o_inflight  out  CW  issued-not-retired count.
o_stall_cycles  out  32  saturating count of STALL cycles.
o_state  out  issue_state_t  current FSM state, for verification.

Behaviour:
- Reset (async): state EMPTY, hold register cleared (all fields 0), busy mask 0, inflight 0, stall counter 0, o_ex_valid 0. o_de_ready is 1 once EMPTY.
- Handshakes:
  - Accept when i_de_valid & o_de_ready.
  - Issue when o_ex_valid & i_ex_ready.
  - o_ex_* are stable while o_ex_valid=1 and not issued.
- Latency: an instruction accepted at edge N can issue at the earliest in the cycle after edge N. Throughput is 1 instruction per cycle with no hazards.
- Effective busy: eb = busy_mask & ~(i_wb_we ? onehot(i_wb_rd) : 0). Writeback in the same cycle removes the hazard.
- hazard = (rs1_used & eb[rs1]) | (rs2_used & eb[rs2]) | (rd_we & eb[rd]). Register 0 never causes a hazard.
- credit_ok = (inflight - i_retire) < MAX_INFLIGHT.
- can_issue = held & !hazard & credit_ok & !i_flush. o_ex_valid = can_issue (combinational on registered state and scoreboard).
- o_de_ready = !i_flush & (state==EMPTY | issuing this cycle).
- FSM states:
  - EMPTY: on accept → VALID, else stay.
  - VALID: issue & accept → VALID; issue only → EMPTY; blocked (hazard or !credit_ok) → STALL; i_ex_ready=0 with no hazard → stay VALID.
  - STALL: the same exits as VALID once unblocked; stays STALL while blocked.
  - FLUSH: entered from any state on i_flush. Hold register is dropped, o_de_ready=0, o_ex_valid=0. Next cycle → EMPTY. i_flush held high keeps the FSM in FLUSH.
- Flush does not touch the scoreboard or inflight count: already-issued instructions still write back and retire.
- Scoreboard update per edge:
  - Clear bit i_wb_rd if i_wb_we.
  - Set bit o_ex_rd if issuing with rd_we and rd≠0.
  - If set and clear hit the same bit, set wins.
- inflight: +1 on issue, -1 on i_retire; both in one cycle → unchanged. i_retire at 0 is ignored (no underflow). i_wb_we on a non-busy bit is ignored.
- o_stall_cycles increments each cycle in STALL and saturates at 0xFFFF_FFFF.
- Reset mid-operation clears everything immediately, including busy bits of in-flight instructions.

Decomposition:
- rapid_pkg adds:
  - typedef enum issue_state_t {EMPTY, VALID, STALL, FLUSH};
  - struct issue_slot_s {pc, imm, control, rs1, rs2, rd, rs1_used, rs2_used, rd_we};
  - constant REG_COUNT=32.
- Sub-module reg_scoreboard holds the busy mask, set/clear priority and effective-busy lookup for three read indices. issue_controller keeps the FSM, hold register, credits and counter.

Test Plan:
- Reset then ADD x5←x1,x2 (rd_we=1), i_ex_ready=1 → o_ex_valid the cycle after accept; busy_mask=0x0000_0020; inflight=1.
- x5 busy, accept SUB rs1=x5 → STALL, o_ex_valid=0, stall counter counts up. i_wb_we=1, i_wb_rd=5 → issues in that same cycle, bit 5 is set again by SUB (rd=x5), busy_mask=0x20.
- MAX_INFLIGHT=4 with four independent issues and no retire → fifth instruction STALL, inflight=4. i_retire pulse → fifth issues the same cycle, inflight stays 4.
- Instruction with rd=x0, rd_we=1 → busy_mask stays 0; next instruction reading x0 issues with no stall.
- i_flush while a held instruction is stalled → state FLUSH for one cycle, o_de_ready=0, hold dropped, busy_mask and inflight unchanged, then EMPTY.
- Assert i_reset mid-STALL with busy_mask=0x0000_0106 and inflight=2 → all outputs 0, state EMPTY, no issue of the held instruction.
